// File: rtl/mem_march_bist_if.sv
// Simple dual-port memory bus: one write port and one read port with
// fixed read latency. The BIST drives the master side; the BRAM is the slave.
interface mem_march_bist_if #(
  parameter int ALEN = 1,
  parameter int DLEN = 8
);
  logic            wen;
  logic [ALEN-1:0] waddr;
  logic [DLEN-1:0] wdata;
  logic            ren;
  logic [ALEN-1:0] raddr;
  logic [DLEN-1:0] rdata;

  modport master (output wen, waddr, wdata, ren, raddr, input rdata);
  modport slave  (input wen, waddr, wdata, ren, raddr, output rdata);
endinterface

// File: rtl/mem_march_bist.sv
// March C- BIST initiator for a BRAM with RD_LAT-cycle read latency.
// Optional MEM_MARCH_BIST_ERRCNT_EN: run to completion and count mismatches.
module mem_march_bist #(
  parameter int ALEN   = 1,
  parameter int DLEN   = 8,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [ALEN-1:0] fail_addr_o,
  output logic [2:0]      fail_elem_o,
  mem_march_bist_if.master mem_if
`ifdef MEM_MARCH_BIST_ERRCNT_EN
  ,
  output logic [15:0]     err_cnt_o
`endif
);

  typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, CHK, DONE} state_t;

  localparam int              WW        = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
  localparam logic [WW-1:0]   WAIT_LAST = WW'((RD_LAT > 1) ? (RD_LAT - 2) : 0);
  localparam logic [ALEN-1:0] ADDR_MAX  = '1;
  localparam logic [2:0]      ELEM_LAST = 3'd5;

  state_t          state_q, state_d;
  logic [ALEN-1:0] addr_q, addr_d;
  logic [2:0]      elem_q, elem_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [ALEN-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]      fail_elem_q, fail_elem_d;
`ifdef MEM_MARCH_BIST_ERRCNT_EN
  logic [15:0]     err_cnt_q, err_cnt_d;
`endif

  // Per-element decode: direction, last address, read and write backgrounds.
  logic            elem_down;
  logic [ALEN-1:0] addr_last;
  logic [ALEN-1:0] addr_step;
  logic [ALEN-1:0] next_start;
  logic [DLEN-1:0] exp_rd;
  logic [DLEN-1:0] wr_pat;
  logic            mismatch;

  always_comb begin
    elem_down  = (elem_q == 3'd3) || (elem_q == 3'd4);
    addr_last  = elem_down ? '0 : ADDR_MAX;
    addr_step  = elem_down ? (addr_q - ALEN'(1)) : (addr_q + ALEN'(1));
    next_start = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
    exp_rd     = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? '1 : '0;
    wr_pat     = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? '1 : '0;
    mismatch   = (mem_if.rdata != exp_rd);
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    elem_d        = elem_q;
    wait_d        = wait_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_addr_d   = fail_addr_q;
    fail_elem_d   = fail_elem_q;
`ifdef MEM_MARCH_BIST_ERRCNT_EN
    err_cnt_d     = err_cnt_q;
`endif
    mem_if.wen    = 1'b0;
    mem_if.waddr  = '0;
    mem_if.wdata  = '0;
    mem_if.ren    = 1'b0;
    mem_if.raddr  = '0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = WR;
          addr_d      = '0;
          elem_d      = 3'd0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = 3'd0;
`ifdef MEM_MARCH_BIST_ERRCNT_EN
          err_cnt_d   = '0;
`endif
        end
      end

      WR: begin
        mem_if.wen   = 1'b1;
        mem_if.waddr = addr_q;
        if (addr_q == ADDR_MAX) begin
          state_d = RD;
          addr_d  = '0;
          elem_d  = 3'd1;
        end else begin
          addr_d  = addr_q + ALEN'(1);
        end
      end

      RD: begin
        mem_if.ren   = 1'b1;
        mem_if.raddr = addr_q;
        wait_d       = '0;
        state_d      = (RD_LAT > 1) ? RWAIT : CHK;
      end

      RWAIT: begin
        if (wait_q == WAIT_LAST) state_d = CHK;
        else                     wait_d  = wait_q + WW'(1);
      end

      CHK: begin
`ifdef MEM_MARCH_BIST_ERRCNT_EN
        if (mismatch) begin
          if (err_cnt_q == '0) begin
            fail_addr_d = addr_q;
            fail_elem_d = elem_q;
          end
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
        if (elem_q != ELEM_LAST) begin
          mem_if.wen   = 1'b1;
          mem_if.waddr = addr_q;
          mem_if.wdata = wr_pat;
        end
        if (addr_q == addr_last) begin
          if (elem_q == ELEM_LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == '0);
          end else begin
            state_d = RD;
            elem_d  = elem_q + 3'd1;
            addr_d  = next_start;
          end
        end else begin
          state_d = RD;
          addr_d  = addr_step;
        end
`else
        if (mismatch) begin
          // Abort: no write this cycle, record where the march first broke.
          state_d     = DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          pass_d      = 1'b0;
          fail_addr_d = addr_q;
          fail_elem_d = elem_q;
        end else begin
          if (elem_q != ELEM_LAST) begin
            mem_if.wen   = 1'b1;
            mem_if.waddr = addr_q;
            mem_if.wdata = wr_pat;
          end
          if (addr_q == addr_last) begin
            if (elem_q == ELEM_LAST) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = 1'b1;
            end else begin
              state_d = RD;
              elem_d  = elem_q + 3'd1;
              addr_d  = next_start;
            end
          end else begin
            state_d = RD;
            addr_d  = addr_step;
          end
        end
`endif
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop regardless of process order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      elem_q      <= 3'd0;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
`ifdef MEM_MARCH_BIST_ERRCNT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      elem_q      <= elem_d;
      wait_q      <= wait_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
`ifdef MEM_MARCH_BIST_ERRCNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;
`ifdef MEM_MARCH_BIST_ERRCNT_EN
  assign err_cnt_o   = err_cnt_q;
`endif

endmodule

// File: tb/tb_mem_march_bist.sv
// Directed bench for mem_march_bist: three instances (ALEN=2/RD_LAT=1,
// ALEN=2/RD_LAT=3, ALEN=1/RD_LAT=1) on behavioural BRAMs with fault injection.
module tb_mem_march_bist;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] start_v;

  always #5 clk = ~clk;

  mem_march_bist_if #(.ALEN(2), .DLEN(8)) bus_a ();
  mem_march_bist_if #(.ALEN(2), .DLEN(8)) bus_b ();
  mem_march_bist_if #(.ALEN(1), .DLEN(8)) bus_c ();

  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
  logic [1:0] faddr_a, faddr_b;
  logic [0:0] faddr_c;
  logic [2:0] felem_a, felem_b, felem_c;
`ifdef MEM_MARCH_BIST_ERRCNT_EN
  logic [15:0] err_a, err_b, err_c;
`endif

  mem_march_bist #(.ALEN(2), .DLEN(8), .RD_LAT(1)) dut_a (
    .clk(clk), .rstn(rstn), .start_i(start_v[0]), .busy_o(busy_a), .done_o(done_a),
    .pass_o(pass_a), .fail_addr_o(faddr_a), .fail_elem_o(felem_a), .mem_if(bus_a)
`ifdef MEM_MARCH_BIST_ERRCNT_EN
    , .err_cnt_o(err_a)
`endif
  );
  mem_march_bist #(.ALEN(2), .DLEN(8), .RD_LAT(3)) dut_b (
    .clk(clk), .rstn(rstn), .start_i(start_v[1]), .busy_o(busy_b), .done_o(done_b),
    .pass_o(pass_b), .fail_addr_o(faddr_b), .fail_elem_o(felem_b), .mem_if(bus_b)
`ifdef MEM_MARCH_BIST_ERRCNT_EN
    , .err_cnt_o(err_b)
`endif
  );
  mem_march_bist #(.ALEN(1), .DLEN(8), .RD_LAT(1)) dut_c (
    .clk(clk), .rstn(rstn), .start_i(start_v[2]), .busy_o(busy_c), .done_o(done_c),
    .pass_o(pass_c), .fail_addr_o(faddr_c), .fail_elem_o(felem_c), .mem_if(bus_c)
`ifdef MEM_MARCH_BIST_ERRCNT_EN
    , .err_cnt_o(err_c)
`endif
  );

  logic [2:0] o_busy, o_done, o_wen, o_ren;
  assign o_busy = {busy_c, busy_b, busy_a};
  assign o_done = {done_c, done_b, done_a};
  assign o_wen  = {bus_c.wen, bus_b.wen, bus_a.wen};
  assign o_ren  = {bus_c.ren, bus_b.ren, bus_a.ren};

  // Fault configuration for memory A; ren_cnt is the 1-based index of the read in flight.
  int         f_sa_addr;
  logic [7:0] f_sa1, f_sa0, f_flip_mask;
  int         f_flip_rd;
  int         ren_cnt;

  function automatic logic [7:0] faulty(input logic [7:0] d, input logic [1:0] a, input int rn);
    logic [7:0] r;
    r = d;
    if (int'(a) == f_sa_addr) r = (r | f_sa1) & ~f_sa0;
    if (rn == f_flip_rd) r = r ^ f_flip_mask;
    return r;
  endfunction

  logic [7:0] mem_a [4];
  logic [7:0] mem_b [4];
  logic [7:0] mem_c [2];
  logic [7:0] rdq_a, rdq_c, pb0, pb1, pb2;

  always @(posedge clk) begin
    if (bus_a.wen) mem_a[bus_a.waddr] <= bus_a.wdata;
    if (bus_a.ren) rdq_a <= faulty(mem_a[bus_a.raddr], bus_a.raddr, ren_cnt);
    if (bus_b.wen) mem_b[bus_b.waddr] <= bus_b.wdata;
    if (bus_b.ren) pb0 <= mem_b[bus_b.raddr];
    pb1 <= pb0;
    pb2 <= pb1;
    if (bus_c.wen) mem_c[bus_c.waddr] <= bus_c.wdata;
    if (bus_c.ren) rdq_c <= mem_c[bus_c.raddr];
  end
  assign bus_a.rdata = rdq_a;
  assign bus_b.rdata = pb2;
  assign bus_c.rdata = rdq_c;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int sel);
    return (sel == 1) ? 3 : 1;
  endfunction

  // Start one instance and count busy cycles and accesses until done, plus a short tail.
  task automatic run(input int sel, input bit restart, output int busy_cyc, output int wen_n,
                     output int ren_n, output int lat_bad, output bit to);
    int cyc, last_ren;
    busy_cyc = 0; wen_n = 0; lat_bad = 0; to = 0; cyc = 0; last_ren = -100;
    ren_cnt = 0;
    @(negedge clk); start_v[sel] = 1'b1;
    @(negedge clk); start_v = '0;
    forever begin
      if (o_done[sel]) break;
      if (cyc >= 400) begin to = 1; break; end
      if (o_busy[sel]) busy_cyc++;
      if (o_wen[sel]) begin
        wen_n++;
        if (ren_cnt > 0 && (cyc - last_ren) != lat_of(sel)) lat_bad++;
      end
      if (o_ren[sel]) begin ren_cnt++; last_ren = cyc; end
      start_v[sel] = restart && (busy_cyc == 10);
      cyc++;
      @(negedge clk);
    end
    start_v = '0;
    repeat (4) begin
      if (o_wen[sel]) wen_n++;
      if (o_ren[sel]) ren_cnt++;
      if (o_busy[sel]) busy_cyc++;
      @(negedge clk);
    end
    ren_n = ren_cnt;
  endtask

  typedef struct {
    int         sa_addr;
    logic [7:0] sa1, sa0;
    int         flip_rd;
    logic [7:0] flip_mask;
    int         busy, wen, ren;
    logic       pass;
    int         faddr, felem, err;
  } vec_t;

  function automatic vec_t mk(input int sa_addr, input logic [7:0] sa1, input logic [7:0] sa0,
                              input int flip_rd, input logic [7:0] flip_mask, input int busy,
                              input int wen, input int ren, input logic pass, input int faddr,
                              input int felem, input int err);
    vec_t v;
    v.sa_addr = sa_addr; v.sa1 = sa1; v.sa0 = sa0; v.flip_rd = flip_rd; v.flip_mask = flip_mask;
    v.busy = busy; v.wen = wen; v.ren = ren; v.pass = pass;
    v.faddr = faddr; v.felem = felem; v.err = err;
    return v;
  endfunction

  vec_t vecs [8];

  task automatic set_fault(input vec_t v);
    f_sa_addr = v.sa_addr; f_sa1 = v.sa1; f_sa0 = v.sa0;
    f_flip_rd = v.flip_rd; f_flip_mask = v.flip_mask;
  endtask

  initial begin
    int  bc, wn, rn, lb;
    bit  to;
    vec_t ideal;

    // Faults on memory A: stuck-at bits (sa1/sa0 at sa_addr) and a one-shot flip of read #flip_rd.
    ideal = mk(0, 8'h00, 8'h00, 0, 8'h00, 44, 20, 20, 1'b1, 0, 0, 0);
    vecs[0] = ideal;
`ifdef MEM_MARCH_BIST_ERRCNT_EN
    vecs[1] = mk(2, 8'h01, 8'h00, 0,  8'h00, 44, 20, 20, 1'b0, 2, 1, 3);
    vecs[2] = mk(1, 8'h00, 8'h80, 0,  8'h00, 44, 20, 20, 1'b0, 1, 2, 2);
    vecs[3] = mk(3, 8'h01, 8'h00, 0,  8'h00, 44, 20, 20, 1'b0, 3, 1, 3);
    vecs[4] = mk(0, 8'h00, 8'h00, 1,  8'h01, 44, 20, 20, 1'b0, 0, 1, 1);
    vecs[5] = mk(0, 8'h00, 8'h00, 10, 8'h80, 44, 20, 20, 1'b0, 2, 3, 1);
    vecs[6] = mk(0, 8'h00, 8'h00, 13, 8'h10, 44, 20, 20, 1'b0, 3, 4, 1);
    vecs[7] = mk(0, 8'h00, 8'h00, 20, 8'h04, 44, 20, 20, 1'b0, 3, 5, 1);
`else
    vecs[1] = mk(2, 8'h01, 8'h00, 0,  8'h00, 10, 6,  3,  1'b0, 2, 1, 0);
    vecs[2] = mk(1, 8'h00, 8'h80, 0,  8'h00, 16, 9,  6,  1'b0, 1, 2, 0);
    vecs[3] = mk(3, 8'h01, 8'h00, 0,  8'h00, 12, 7,  4,  1'b0, 3, 1, 0);
    vecs[4] = mk(0, 8'h00, 8'h00, 1,  8'h01, 6,  4,  1,  1'b0, 0, 1, 0);
    vecs[5] = mk(0, 8'h00, 8'h00, 10, 8'h80, 24, 13, 10, 1'b0, 2, 3, 0);
    vecs[6] = mk(0, 8'h00, 8'h00, 13, 8'h10, 30, 16, 13, 1'b0, 3, 4, 0);
    vecs[7] = mk(0, 8'h00, 8'h00, 20, 8'h04, 44, 20, 20, 1'b0, 3, 5, 0);
`endif
    set_fault(ideal);
    ren_cnt = 0;
    start_v = '0;
    rstn = 1'b0;
    #1;
    check("reset outputs A", {busy_a, done_a, pass_a, faddr_a, felem_a, bus_a.wen, bus_a.ren,
                              bus_a.waddr, bus_a.wdata, bus_a.raddr}, 0);
    check("reset outputs B/C", {busy_b, done_b, pass_b, busy_c, done_c, pass_c,
                                bus_b.wen, bus_b.ren, bus_c.wen, bus_c.ren}, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      set_fault(vecs[i]);
      run(0, 1'b0, bc, wn, rn, lb, to);
      check($sformatf("v%0d timeout", i), 32'(to), 0);
      check($sformatf("v%0d busy cycles", i), bc, vecs[i].busy);
      check($sformatf("v%0d wen count", i), wn, vecs[i].wen);
      check($sformatf("v%0d ren count", i), rn, vecs[i].ren);
      check($sformatf("v%0d write latency", i), lb, 0);
      check($sformatf("v%0d done", i), 32'(done_a), 1);
      check($sformatf("v%0d pass", i), 32'(pass_a), 32'(vecs[i].pass));
      check($sformatf("v%0d fail_addr", i), 32'(faddr_a), vecs[i].faddr);
      check($sformatf("v%0d fail_elem", i), 32'(felem_a), vecs[i].felem);
`ifdef MEM_MARCH_BIST_ERRCNT_EN
      check($sformatf("v%0d err_cnt", i), 32'(err_a), vecs[i].err);
`endif
    end
    set_fault(ideal);

    // start pulsed again while busy must not restart or extend the run.
    run(0, 1'b1, bc, wn, rn, lb, to);
    check("restart timeout", 32'(to), 0);
    check("restart busy cycles", bc, 44);
    check("restart wen count", wn, 20);
    check("restart pass", 32'(pass_a), 1);

    // RD_LAT=3: 84 busy cycles, every compare (and its write) 3 cycles after ren.
    run(1, 1'b0, bc, wn, rn, lb, to);
    check("lat3 timeout", 32'(to), 0);
    check("lat3 busy cycles", bc, 84);
    check("lat3 wen/ren", {wn[15:0], rn[15:0]}, {16'd20, 16'd20});
    check("lat3 compare latency", lb, 0);
    check("lat3 result", {done_b, pass_b, faddr_b, felem_b}, 7'b11_00_000);

    // ALEN=1: two addresses, both directions wrap correctly.
    run(2, 1'b0, bc, wn, rn, lb, to);
    check("alen1 timeout", 32'(to), 0);
    check("alen1 busy cycles", bc, 22);
    check("alen1 wen/ren", {wn[15:0], rn[15:0]}, {16'd10, 16'd10});
    check("alen1 result", {done_c, pass_c, faddr_c, felem_c}, 6'b11_0_000);

    // Asynchronous reset in the middle of E3, then a clean rerun.
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v = '0;
    repeat (23) @(negedge clk);
    check("pre-reset busy", 32'(busy_a), 1);
    #2 rstn = 1'b0;
    #1;
    check("mid-test reset outputs", {busy_a, done_a, pass_a, faddr_a, felem_a, bus_a.wen,
                                     bus_a.ren, bus_a.waddr, bus_a.wdata, bus_a.raddr}, 0);
`ifdef MEM_MARCH_BIST_ERRCNT_EN
    check("mid-test reset err_cnt", 32'(err_a), 0);
`endif
    @(negedge clk);
    check("held reset accesses", {bus_a.wen, bus_a.ren, busy_a}, 0);
    rstn = 1'b1;
    run(0, 1'b0, bc, wn, rn, lb, to);
    check("post-reset timeout", 32'(to), 0);
    check("post-reset busy cycles", bc, 44);
    check("post-reset wen/ren", {wn[15:0], rn[15:0]}, {16'd20, 16'd20});
    check("post-reset result", {done_a, pass_a, faddr_a, felem_a}, 7'b11_00_000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
